// File: rtl/kb_pkg.sv
// Shared definitions for the keyboard event scheduler slice.
// Holds arbiter state encodings, the requester tag and the packed event layout:
//   event[11:0] = {alt, ctrl, shift, extended, scan[6:0], released}
package kb_pkg;

  // Field widths of a buffered key event.
  localparam int MODW  = 3;    // alt, ctrl, shift
  localparam int SCANW = 7;    // scancode
  localparam int EVW   = 12;   // full event word
  localparam int ADDRW = 11;   // translator keymap address width

  // Bit offsets inside the event word.
  localparam int REL_OFS  = 0;
  localparam int SCAN_OFS = 1;
  localparam int EXT_OFS  = SCAN_OFS + SCANW;   // 8
  localparam int MOD_OFS  = EXT_OFS + 1;        // 9

  // Default event FIFO depth.
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EV_PRESENT = 2'd1,
    CPU_OWN    = 2'd2
  } state_e;

  // Which requester was granted the keymap most recently.
  typedef enum logic {
    SRV_EV  = 1'b0,
    SRV_CPU = 1'b1
  } served_e;

  // Pack one PS/2 event into the FIFO word layout.
  function automatic logic [EVW-1:0] pack_event(
    input logic             alt,
    input logic             ctrl,
    input logic             shift,
    input logic             ext,
    input logic [SCANW-1:0] scan,
    input logic             rel
  );
    return {alt, ctrl, shift, ext, scan, rel};
  endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// Synchronous FIFO for key events with first-word-fall-through head output.
// Latency: pushed word is visible at the head (and in level_o) the cycle after the push.
// Backpressure: a push while full is dropped (drop_o) unless a pop happens the same cycle.
// Ports:
//   clk, rst               clock, synchronous active-high reset (empties the FIFO)
//   push_i, push_dat_i     write request and word
//   pop_i                  remove the head word (ignored when empty)
//   head_dat_o             current head word, valid whenever empty_o=0
//   empty_o, level_o       occupancy status
//   drop_o                 this cycle's push was discarded because the FIFO stayed full
module kb_event_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_dat_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          drop_o
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];

  // One extra pointer bit distinguishes full from empty; the low AW bits
  // index the storage, so wrapping is modulo DEPTH (DEPTH is a power of 2).
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic full;
  logic pop_ok;
  logic push_ok;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (level_o == '0);
  assign full    = (level_o == DEPTH_L);

  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the new word needs.
  assign push_ok = push_i && (!full || pop_ok);
  assign drop_o  = push_i && !push_ok;

  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed between the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
  end

endmodule

// File: rtl/kb_event_scheduler.sv
// Buffers PS/2 key events and arbitrates the translator keymap between key events and CPU accesses.
// Latency: event into empty FIFO in IDLE shows on ev_valid 2 cycles after scan_received; cpu_grant 1 cycle after cpu_req.
// Backpressure: ev_valid/ev_ready handshake holds the event; FIFO absorbs DEPTH events, further ones are dropped and flag overflow.
// Ports:
//   clk, rst                             clock, synchronous active-high reset
//   scan_received, scan, extended,
//   released, *_pressed                  event pulse plus fields, modifiers sampled with the pulse
//   ev_valid, ev_addr, ev_released,
//   ev_ready                             event handshake toward the translator
//   cpu_req, cpu_grant                   CPU keymap ownership request/grant
//   ovf_clear, overflow                  sticky dropped-event flag and its clear
//   level                                FIFO occupancy
module kb_event_scheduler
  import kb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_received,
  input  logic [SCANW-1:0]  scan,
  input  logic              extended,
  input  logic              released,
  input  logic              shift_pressed,
  input  logic              ctrl_pressed,
  input  logic              alt_pressed,
  output logic              ev_valid,
  output logic [ADDRW-1:0]  ev_addr,
  output logic              ev_released,
  input  logic              ev_ready,
  input  logic              cpu_req,
  output logic              cpu_grant,
  input  logic              ovf_clear,
  output logic              overflow,
  output logic [AW:0]       level
);

  logic [EVW-1:0] push_dat;
  logic [EVW-1:0] head_dat;
  logic           fifo_empty;
  logic           fifo_pop;
  logic           fifo_drop;

  state_e              state_q;
  served_e             last_served_q;
  logic                ev_valid_q;
  logic                cpu_grant_q;
  logic [ADDRW-1:0]    ev_addr_q;
  logic                ev_released_q;
  logic                overflow_q;

  assign push_dat = pack_event(alt_pressed, ctrl_pressed, shift_pressed,
                               extended, scan, released);

  // The head is only removed on the accepting edge of a presented event.
  assign fifo_pop = (state_q == EV_PRESENT) && ev_ready;

  kb_event_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (EVW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (scan_received),
    .push_dat_i (push_dat),
    .pop_i      (fifo_pop),
    .head_dat_o (head_dat),
    .empty_o    (fifo_empty),
    .level_o    (level),
    .drop_o     (fifo_drop)
  );

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (fifo_drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clear) begin
      overflow_q <= 1'b0;
    end
  end

  // Arbiter. Outputs are registered and change only on state transitions, so
  // ev_valid and cpu_grant can never be high together: each is only raised
  // from IDLE, where both are low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_served_q <= SRV_CPU;
      ev_valid_q    <= 1'b0;
      cpu_grant_q   <= 1'b0;
      ev_addr_q     <= '0;
      ev_released_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // With both requesters pending, the one not served last goes first.
          if (!fifo_empty && (!cpu_req || (last_served_q == SRV_CPU))) begin
            state_q       <= EV_PRESENT;
            ev_valid_q    <= 1'b1;
            ev_addr_q     <= head_dat[EVW-1:SCAN_OFS];
            ev_released_q <= head_dat[REL_OFS];
          end else if (cpu_req) begin
            state_q     <= CPU_OWN;
            cpu_grant_q <= 1'b1;
          end
        end

        EV_PRESENT: begin
          // Event data was latched on entry, so it stays stable while stalled.
          if (ev_ready) begin
            state_q       <= IDLE;
            ev_valid_q    <= 1'b0;
            last_served_q <= SRV_EV;
          end
        end

        CPU_OWN: begin
          if (!cpu_req) begin
            state_q       <= IDLE;
            cpu_grant_q   <= 1'b0;
            last_served_q <= SRV_CPU;
          end
        end

        default: begin
          state_q     <= IDLE;
          ev_valid_q  <= 1'b0;
          cpu_grant_q <= 1'b0;
        end
      endcase
    end
  end

  assign ev_valid    = ev_valid_q;
  assign cpu_grant   = cpu_grant_q;
  assign ev_addr     = ev_addr_q;
  assign ev_released = ev_released_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_kb_event_scheduler.sv
module tb_kb_event_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_received = 1'b0;
  logic [6:0]  scan = '0;
  logic        extended = 1'b0;
  logic        released = 1'b0;
  logic        shift_pressed = 1'b0;
  logic        ctrl_pressed = 1'b0;
  logic        alt_pressed = 1'b0;
  logic        ev_ready = 1'b0;
  logic        cpu_req = 1'b0;
  logic        ovf_clear = 1'b0;
  logic        ev_valid;
  logic [10:0] ev_addr;
  logic        ev_released;
  logic        cpu_grant;
  logic        overflow;
  logic [3:0]  level;

  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;

  kb_event_scheduler #(.DEPTH(8), .AW(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .scan_received (scan_received),
    .scan          (scan),
    .extended      (extended),
    .released      (released),
    .shift_pressed (shift_pressed),
    .ctrl_pressed  (ctrl_pressed),
    .alt_pressed   (alt_pressed),
    .ev_valid      (ev_valid),
    .ev_addr       (ev_addr),
    .ev_released   (ev_released),
    .ev_ready      (ev_ready),
    .cpu_req       (cpu_req),
    .cpu_grant     (cpu_grant),
    .ovf_clear     (ovf_clear),
    .overflow      (overflow),
    .level         (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one event word {alt,ctrl,shift,ext,scan,rel} with a scan_received pulse.
  task automatic set_ev(input logic [11:0] e);
    {alt_pressed, ctrl_pressed, shift_pressed, extended, scan, released} = e;
    scan_received = 1'b1;
  endtask

  // Events of the overflow batch: ctrl=i[0], ext=i[1], rel=i[2], scan=0x20+i.
  function automatic logic [11:0] bat(input int i);
    logic [6:0] s;
    logic [2:0] b;
    s = 7'h20 + 7'(i);
    b = 3'(i);
    return {1'b0, b[0], 1'b0, b[1], s, b[2]};
  endfunction

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!ev_valid && n < 8) begin
      tick();
      n++;
    end
    check(tag, 32'(ev_valid), 32'd1);
  endtask

  task automatic check_head(input string tag, input logic [11:0] e);
    check(tag, 32'(ev_addr), 32'(e[11:1]));
    check({tag, "_rel"}, 32'(ev_released), 32'(e[0]));
  endtask

  // Grant and valid must never be asserted together.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      assert (!(ev_valid && cpu_grant)) else begin
        bad++;
        $error("FAIL overlap observed=valid&grant expected=exclusive");
      end
    end
  end

  logic [11:0] ev_a, ev_b, ev_c, ev_d, ev_e;
  int          kinds[6];
  logic [10:0] addrs[6];
  int          nrec;
  int          gcnt;

  initial begin
    ev_a = {1'b1, 1'b0, 1'b0, 1'b1, 7'h7F, 1'b1};
    ev_b = {1'b0, 1'b0, 1'b1, 1'b1, 7'h11, 1'b0};
    ev_c = {1'b0, 1'b1, 1'b0, 1'b0, 7'h22, 1'b1};
    ev_d = {1'b0, 1'b1, 1'b1, 1'b0, 7'h33, 1'b0};
    ev_e = {1'b1, 1'b0, 1'b0, 1'b0, 7'h55, 1'b0};

    // Reset state
    rst = 1'b1;
    tick();
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_grant", 32'(cpu_grant), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_addr", 32'(ev_addr), 32'd0);
    check("rst_rel", 32'(ev_released), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single event: scan 1C with shift
    set_ev({1'b0, 1'b0, 1'b1, 1'b0, 7'h1C, 1'b0});
    tick();
    scan_received = 1'b0;
    check("single_lvl1", 32'(level), 32'd1);
    check("single_notyet", 32'(ev_valid), 32'd0);
    tick();
    check("single_valid", 32'(ev_valid), 32'd1);
    check("single_addr", 32'(ev_addr), 32'h11C);
    check("single_rel", 32'(ev_released), 32'd0);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("single_done", 32'(ev_valid), 32'd0);
    check("single_lvl0", 32'(level), 32'd0);

    // Overflow while the CPU owns the keymap
    cpu_req = 1'b1;
    tick();
    check("grant_lat", 32'(cpu_grant), 32'd1);
    for (int i = 0; i < 9; i++) begin
      set_ev(bat(i));
      ovf_clear = (i == 8);   // drop coincides with a clear: set must win
      tick();
    end
    scan_received = 1'b0;
    ovf_clear = 1'b0;
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    cpu_req = 1'b0;
    tick();
    check("ovf_release", 32'(cpu_grant), 32'd0);
    tick();
    check("ovf_headv", 32'(ev_valid), 32'd1);
    check_head("ovf_head", bat(0));
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_hold", 32'(ev_valid), 32'd1);

    // Push and pop together while full
    set_ev(ev_e);
    ev_ready = 1'b1;
    tick();
    scan_received = 1'b0;
    ev_ready = 1'b0;
    check("pp_level", 32'(level), 32'd8);
    check("pp_ovf", 32'(overflow), 32'd0);
    check("pp_valid", 32'(ev_valid), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      wait_valid("drain_wait");
      check_head("drain_addr", (k == 8) ? ev_e : bat(k));
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
    end
    check("drain_empty", 32'(level), 32'd0);

    // Stall: data stable while ev_ready low, pushes still land
    set_ev(ev_a);
    tick();
    scan_received = 1'b0;
    tick();
    check("stall_valid", 32'(ev_valid), 32'd1);
    check("stall_a", 32'(ev_addr), 32'h4FF);
    for (int s = 0; s < 5; s++) begin
      if (s == 0) set_ev(ev_b);
      else if (s == 1) set_ev(ev_c);
      else scan_received = 1'b0;
      tick();
      check("stall_hold", 32'(ev_valid), 32'd1);
      check_head("stall_data", ev_a);
    end
    check("stall_level", 32'(level), 32'd3);

    // Alternation: accept A, then CPU and events take turns
    set_ev(ev_d);
    ev_ready = 1'b1;
    cpu_req = 1'b1;
    tick();
    scan_received = 1'b0;
    check("alt_level", 32'(level), 32'd3);
    nrec = 0;
    gcnt = 0;
    for (int cyc = 0; cyc < 60 && nrec < 6; cyc++) begin
      tick();
      if (ev_valid) begin
        kinds[nrec] = 0;
        addrs[nrec] = ev_addr;
        nrec++;
      end else if (cpu_grant) begin
        if (gcnt == 0) begin
          kinds[nrec] = 1;
          addrs[nrec] = '0;
          nrec++;
        end
        gcnt++;
        if (gcnt == 3) cpu_req = 1'b0;
      end else if (!cpu_req) begin
        cpu_req = 1'b1;
        gcnt = 0;
      end
    end
    check("alt_count", 32'(nrec), 32'd6);
    for (int k = 0; k < 6 && k < nrec; k++) begin
      check("alt_kind", 32'(kinds[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    if (nrec == 6) begin
      check("alt_ev_b", 32'(addrs[1]), 32'(ev_b[11:1]));
      check("alt_ev_c", 32'(addrs[3]), 32'(ev_c[11:1]));
      check("alt_ev_d", 32'(addrs[5]), 32'(ev_d[11:1]));
    end

    // Reset in the middle of a grant with queued events
    tick();
    ev_ready = 1'b0;
    tick();
    check("mg_grant", 32'(cpu_grant), 32'd1);
    check("mg_empty", 32'(level), 32'd0);
    set_ev(ev_b);
    tick();
    set_ev(ev_c);
    tick();
    check("mg_level", 32'(level), 32'd2);
    rst = 1'b1;
    set_ev(ev_a);
    tick();
    rst = 1'b0;
    scan_received = 1'b0;
    check("mg_rst_grant", 32'(cpu_grant), 32'd0);
    check("mg_rst_valid", 32'(ev_valid), 32'd0);
    check("mg_rst_level", 32'(level), 32'd0);
    check("mg_rst_ovf", 32'(overflow), 32'd0);
    tick();
    check("mg_regrant", 32'(cpu_grant), 32'd1);
    cpu_req = 1'b0;
    tick();
    check("mg_drop", 32'(cpu_grant), 32'd0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
